text_ram_ctrl: RTL and testbench

Write-side sequencer for the 80-column character RAM. Consumes a byte stream of characters and control codes, keeps a wrapping cursor, and turns each byte into at most one registered RAM write. Also runs a screen clear engine and arbitrates a direct host "poke" port against the stream for the single RAM write port. Sits between the character source (UART/console logic) and the RAM's `write_en`/`waddr`/`din` inputs; the RAM's `wclk` is tied to `clk`.

---
 rtl/text_ram_ctrl.sv | 159 +++++++++++++++
 tb/tb_text_ram_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ram_ctrl.sv
// Write-side sequencer for the 80-column character RAM: turns a byte stream into
// cursor-driven registered RAM writes, runs the screen clear and arbitrates host pokes.
module text_ram_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int COLS = 80,
  parameter logic [DATA_W-1:0] BLANK = DATA_W'(8'h20)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              poke_valid,
  input  logic [ADDR_W-1:0] poke_addr,
  input  logic [DATA_W-1:0] poke_data,
  output logic              poke_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_din,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both
  // high; the source holds its data stable until it sees ready, and ready never
  // depends on the matching valid.

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] FIRST_CELL = '0;
  localparam logic [ADDR_W-1:0] ONE_CELL   = ADDR_W'(1);

  localparam logic [DATA_W-1:0] CH_FF = DATA_W'(8'h0C);
  localparam logic [DATA_W-1:0] CH_CR = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] CH_LF = DATA_W'(8'h0A);
  localparam logic [DATA_W-1:0] CH_BS = DATA_W'(8'h08);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              busy_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] din_q, din_d;

  logic poke_fire;
  logic stream_fire;

  // Cursor stepping compares explicitly against the last cell, so COLS need not
  // be a power of two.
  function automatic logic [ADDR_W-1:0] cell_next(input logic [ADDR_W-1:0] c);
    return (c == LAST_CELL) ? FIRST_CELL : c + ONE_CELL;
  endfunction

  function automatic logic [ADDR_W-1:0] cell_prev(input logic [ADDR_W-1:0] c);
    return (c == FIRST_CELL) ? LAST_CELL : c - ONE_CELL;
  endfunction

  assign poke_ready  = (state_q == IDLE);
  assign in_ready    = (state_q == IDLE) && !poke_valid;
  assign poke_fire   = poke_valid && poke_ready;
  assign stream_fire = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    cursor_d  = cursor_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    din_d     = din_q;

    case (state_q)
      CLEAR: begin
        we_d    = 1'b1;
        waddr_d = clr_cnt_q;
        din_d   = BLANK;
        if (clr_cnt_q == LAST_CELL) begin
          clr_cnt_d = FIRST_CELL;
          cursor_d  = FIRST_CELL;
          state_d   = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + ONE_CELL;
        end
      end

      IDLE: begin
        if (poke_fire) begin
          // Out-of-range pokes are consumed silently so the host never stalls.
          if (poke_addr <= LAST_CELL) begin
            we_d    = 1'b1;
            waddr_d = poke_addr;
            din_d   = poke_data;
          end
        end else if (stream_fire) begin
          case (in_data)
            CH_FF: begin
              clr_cnt_d = FIRST_CELL;
              state_d   = CLEAR;
            end
            CH_CR: begin
              cursor_d = FIRST_CELL;
            end
            CH_LF: begin
              cursor_d = cursor_q;
            end
            CH_BS: begin
              cursor_d = cell_prev(cursor_q);
              we_d     = 1'b1;
              waddr_d  = cell_prev(cursor_q);
              din_d    = BLANK;
            end
            default: begin
              we_d     = 1'b1;
              waddr_d  = cursor_q;
              din_d    = in_data;
              cursor_d = cell_next(cursor_q);
            end
          endcase
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      cursor_q  <= '0;
      busy_q    <= 1'b1;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      cursor_q  <= cursor_d;
      busy_q    <= (state_d == CLEAR);
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      din_q     <= din_d;
    end
  end

  assign ram_we    = we_q;
  assign ram_waddr = waddr_q;
  assign ram_din   = din_q;
  assign cursor    = cursor_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_text_ram_ctrl.sv
// Self-checking bench for text_ram_ctrl: directed test-plan steps followed by
// randomized traffic, all checked against a cell-array model of the screen.
module tb_text_ram_ctrl;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int COLS = 80;
  localparam int W = ADDR_W + DATA_W;
  localparam logic [7:0] BLANK = 8'h20;

  logic              clk;
  logic              resetn;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              poke_valid;
  logic [ADDR_W-1:0] poke_addr;
  logic [DATA_W-1:0] poke_data;
  logic              poke_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_din;
  logic [ADDR_W-1:0] cursor;
  logic              busy;

  text_ram_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .COLS(COLS),
    .BLANK(BLANK)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .poke_valid(poke_valid),
    .poke_addr(poke_addr),
    .poke_data(poke_data),
    .poke_ready(poke_ready),
    .ram_we(ram_we),
    .ram_waddr(ram_waddr),
    .ram_din(ram_din),
    .cursor(cursor),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard and model ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [7:0]   m_ram[COLS];
  logic [7:0]   obs_ram[COLS];
  int           m_cursor;
  logic         m_busy;
  logic [W-1:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int addr, input logic [7:0] data);
    exp_q.push_back({addr[ADDR_W-1:0], data});
    m_ram[addr] = data;
    m_last = {addr[ADDR_W-1:0], data};
  endtask

  task automatic start_clear();
    for (int i = 0; i < COLS; i++) push(i, BLANK);
    m_busy = 1'b1;
  endtask

  task automatic model_stream(input logic [7:0] b, output logic we);
    we = 1'b0;
    case (b)
      8'h0C: start_clear();
      8'h0D: m_cursor = 0;
      8'h0A: m_cursor = m_cursor;
      8'h08: begin
        m_cursor = (m_cursor + COLS - 1) % COLS;
        push(m_cursor, BLANK);
        we = 1'b1;
      end
      default: begin
        push(m_cursor, b);
        m_cursor = (m_cursor + 1) % COLS;
        we = 1'b1;
      end
    endcase
  endtask

  // Every RAM write the DUT issues must be the next one the model expects.
  always @(negedge clk) begin
    if (resetn && ram_we) begin
      chk("write_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("write_addr_data", {ram_waddr, ram_din}, exp_q.pop_front());
      if (ram_waddr < COLS) obs_ram[ram_waddr] = ram_din;
    end
  end

  // ---------------- driver tasks ----------------
  // One stimulus cycle while idle: drive, check readies, let the edge happen,
  // then check the registered results one half-cycle later.
  task automatic step(input logic iv, input logic [7:0] id, input logic pv,
                      input logic [6:0] pa, input logic [7:0] pd);
    logic exp_we;
    in_valid = iv; in_data = id; poke_valid = pv; poke_addr = pa; poke_data = pd;
    #1;
    chk("poke_ready", poke_ready, 1);
    chk("in_ready", in_ready, !pv);
    @(posedge clk);
    exp_we = 1'b0;
    if (pv) begin
      if (int'(pa) < COLS) begin
        push(int'(pa), pd);
        exp_we = 1'b1;
      end
    end else if (iv) begin
      model_stream(id, exp_we);
    end
    @(negedge clk);
    #1;
    in_valid = 1'b0; poke_valid = 1'b0;
    chk("ram_we", ram_we, exp_we);
    chk("cursor", cursor, m_cursor);
    chk("busy", busy, m_busy);
    if (!m_busy) chk("drained", exp_q.size(), 0);
    if (!exp_we && !m_busy) chk("hold_addr_data", {ram_waddr, ram_din}, m_last);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    in_valid = 1'b1; in_data = 8'h41; poke_valid = 1'b1; poke_addr = 7'd3; poke_data = 8'h55;
    while (n < 200) begin
      @(negedge clk);
      #1;
      n++;
      if (!busy) break;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_poke_ready", poke_ready, 0);
    end
    in_valid = 1'b0; poke_valid = 1'b0;
    chk("clear_cycles", n, COLS);
    chk("clear_drained", exp_q.size(), 0);
    chk("cursor_after_clear", cursor, 0);
    m_cursor = 0;
    m_busy = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_ram_we", ram_we, 0);
    chk("rst_waddr", ram_waddr, 0);
    chk("rst_din", ram_din, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_busy", busy, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_poke_ready", poke_ready, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] b;
    int r;
    int clears;
    resetn = 1'b0;
    in_valid = 1'b0; in_data = '0; poke_valid = 1'b0; poke_addr = '0; poke_data = '0;
    m_cursor = 0; m_busy = 1'b1; m_last = '0;
    for (int i = 0; i < COLS; i++) m_ram[i] = 8'h00;

    // power-on reset and clear
    repeat (2) @(negedge clk);
    #1;
    check_reset_values();
    resetn = 1'b1;
    start_clear();
    wait_idle();

    // "AB"
    step(1, 8'h41, 0, 0, 0);
    step(1, 8'h42, 0, 0, 0);
    chk("ab_cursor", cursor, 2);

    // 80 x 'A' then 'B' from column 0: cursor wraps
    step(1, 8'h0D, 0, 0, 0);
    for (int i = 0; i < COLS; i++) step(1, 8'h41, 0, 0, 0);
    chk("wrap_cursor_zero", cursor, 0);
    step(1, 8'h42, 0, 0, 0);
    chk("wrap_last_write", {ram_waddr, ram_din}, {7'd0, 8'h42});
    chk("wrap_cursor", cursor, 1);

    // backspace at column 0, then CR
    step(1, 8'h0D, 0, 0, 0);
    step(1, 8'h08, 0, 0, 0);
    chk("bs_write", {ram_we, ram_waddr, ram_din}, {1'b1, 7'd79, 8'h20});
    chk("bs_cursor", cursor, 79);
    step(1, 8'h0D, 0, 0, 0);
    chk("cr_no_write", ram_we, 0);
    chk("cr_cursor", cursor, 0);

    // poke beats stream, stream byte follows; out-of-range poke is dropped
    step(1, 8'h41, 1, 7'd5, 8'h7A);
    chk("poke_write", {ram_we, ram_waddr, ram_din}, {1'b1, 7'd5, 8'h7A});
    step(1, 8'h41, 0, 0, 0);
    chk("after_poke_write", {ram_we, ram_waddr, ram_din}, {1'b1, 7'd0, 8'h41});
    step(0, 8'h00, 1, 7'd100, 8'h33);
    chk("poke_oob_no_write", ram_we, 0);
    step(1, 8'h0A, 0, 0, 0);
    chk("lf_cursor", cursor, 1);

    // form feed interrupted by reset at the 40th blank
    step(1, 8'h0C, 0, 0, 0);
    repeat (40) begin
      @(negedge clk);
      #1;
    end
    chk("blanks_before_reset", exp_q.size(), COLS - 40);
    resetn = 1'b0;
    exp_q.delete();
    m_cursor = 0; m_last = '0;
    #1;
    check_reset_values();
    @(negedge clk);
    #1;
    resetn = 1'b1;
    start_clear();
    wait_idle();

    // randomized traffic
    clears = 0;
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0 && clears < 3) b = 8'h0C;
      else if (r == 1) b = 8'h08;
      else if (r == 2) b = 8'h0D;
      else if (r == 3) b = 8'h0A;
      else b = 8'($urandom_range(8'h21, 8'h7E));
      step(1'($urandom_range(0, 1)), b, ($urandom_range(0, 3) == 0),
           7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
      if (m_busy) begin
        clears++;
        wait_idle();
      end
    end

    // final screen contents
    for (int i = 0; i < COLS; i++) chk("screen_cell", obs_ram[i], m_ram[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
